neuron_accumulator: RTL and testbench

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

---
 rtl/neuron_accumulator_if.sv | 30 +++
 rtl/neuron_accumulator.sv | 87 ++++++++
 tb/tb_neuron_accumulator.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_accumulator_if.sv
// rtl/neuron_accumulator_if.sv - product stream, control and result bundle for neuron_accumulator
// The master drives start/products/bias; the slave (the accumulator) returns handshake and result.
interface neuron_accumulator_if #(
  parameter int PixelWidth      = 8,
  parameter int WeightPrecision = 8,
  parameter int NumPixels       = 12288
);
  localparam int ProdWidth = 2 * (WeightPrecision + PixelWidth) + 1;
  localparam int AccWidth  = ProdWidth + $clog2(NumPixels) + 1;

  logic                              start;
  logic                              prod_valid;
  logic signed [ProdWidth-1:0]       prod;
  logic signed [WeightPrecision-1:0] bias;
  logic                              prod_ready;
  logic                              busy;
  logic                              done;
  logic signed [AccWidth-1:0]        sum_out;
  logic                              is_cat;

  modport master (
    output start, prod_valid, prod, bias,
    input  prod_ready, busy, done, sum_out, is_cat
  );

  modport slave (
    input  start, prod_valid, prod, bias,
    output prod_ready, busy, done, sum_out, is_cat
  );
endinterface

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - sums NumPixels signed products plus a bias into a wrap-free accumulator
// Moore FSM IDLE -> ACCUM -> BIAS -> DONE; the result stays on sum_out until the next accepted start.
module neuron_accumulator #(
  parameter int PixelWidth      = 8,
  parameter int WeightPrecision = 8,
  parameter int NumPixels       = 12288
) (
  input  logic                  clk,
  input  logic                  rst,
  neuron_accumulator_if.slave   bus
);
  localparam int ProdWidth = 2 * (WeightPrecision + PixelWidth) + 1;
  localparam int AccWidth  = ProdWidth + $clog2(NumPixels) + 1;
  localparam int CntWidth  = $clog2(NumPixels);
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(NumPixels - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic signed [AccWidth-1:0] acc_q, acc_d;
  logic [CntWidth-1:0]        count_q, count_d;

  logic signed [AccWidth-1:0] prod_ext;
  logic signed [AccWidth-1:0] bias_ext;

  assign prod_ext = {{(AccWidth - ProdWidth){bus.prod[ProdWidth-1]}}, bus.prod};
  assign bias_ext = {{(AccWidth - WeightPrecision){bus.bias[WeightPrecision-1]}}, bus.bias};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
        end
      end
      ACCUM: begin
        if (bus.prod_valid) begin
          acc_d = acc_q + prod_ext;
          // The counter parks on the last index so it never exceeds NumPixels-1.
          if (count_q == LastCount) begin
            state_d = BIAS;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.prod_ready = (state_q == ACCUM);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.sum_out    = acc_q;
  assign bus.is_cat     = ~acc_q[AccWidth-1];
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - self-checking bench for neuron_accumulator against a plain-sum model
module tb_neuron_accumulator;
  localparam int PixelWidth      = 8;
  localparam int WeightPrecision = 8;
  localparam int NumPixels       = 4;
  localparam int ProdWidth       = 2 * (WeightPrecision + PixelWidth) + 1;
  localparam int AccWidth        = ProdWidth + $clog2(NumPixels) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  neuron_accumulator_if #(
    .PixelWidth(PixelWidth), .WeightPrecision(WeightPrecision), .NumPixels(NumPixels)
  ) bus ();

  neuron_accumulator #(
    .PixelWidth(PixelWidth), .WeightPrecision(WeightPrecision), .NumPixels(NumPixels)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int hs_count = 0;

  always @(posedge clk) begin
    if (bus.prod_valid === 1'b1 && bus.prod_ready === 1'b1) hs_count <= hs_count + 1;
  end

  longint prods[$];
  int     gaps[$];

  longint obs_sum, obs_sum_start, obs_sum_end;
  logic   obs_cat, obs_cat_end, obs_busy_start, obs_busy_end;
  int     obs_done_dly, obs_done_cnt, obs_hs;

  function automatic longint model_sum(input longint b);
    longint s = b;
    foreach (prods[k]) s += prods[k];
    return s;
  endfunction

  function automatic longint sum_now();
    return longint'($signed(bus.sum_out));
  endfunction

  // Drives one image from an IDLE negedge and records what the DUT showed.
  task automatic run_image(input longint bias_v, input bit start_mid, input bit start_done);
    int base;
    bus.bias  = WeightPrecision'(bias_v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    obs_busy_start = bus.busy;
    obs_sum_start  = sum_now();
    base           = hs_count;
    foreach (prods[k]) begin
      for (int g = 0; g < gaps[k]; g++) begin
        bus.prod_valid = 1'b0;
        bus.prod       = ProdWidth'($urandom);
        bus.start      = start_mid;
        @(negedge clk);
        bus.start = 1'b0;
      end
      bus.prod_valid = 1'b1;
      bus.prod       = ProdWidth'(prods[k]);
      bus.start      = start_mid && (k == 1);
      @(negedge clk);
      bus.start = 1'b0;
    end
    // Keep offering junk products: none may be taken after the final handshake.
    bus.prod     = ProdWidth'($urandom);
    obs_done_dly = 0;
    obs_done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (bus.done === 1'b1) begin
        if (obs_done_cnt == 0) begin
          obs_done_dly = i;
          obs_sum      = sum_now();
          obs_cat      = bus.is_cat;
        end
        obs_done_cnt++;
        bus.start = start_done;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.prod_valid = 1'b0;
    obs_sum_end    = sum_now();
    obs_cat_end    = bus.is_cat;
    obs_busy_end   = bus.busy;
    obs_hs         = hs_count - base;
  endtask

  task automatic test_reset();
    #1;
    if (bus.prod_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", bus.prod_ready); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus.done); else n_pass++;
    n_checks++;
    if (sum_now() !== 64'sd0) $display("FAIL rst_sum: got %0d expected 0", sum_now()); else n_pass++;
    n_checks++;
    if (bus.is_cat !== 1'b1) $display("FAIL rst_is_cat: got %b expected 1", bus.is_cat); else n_pass++;
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    if (bus.busy !== 1'b0) $display("FAIL idle_wait_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++;
  endtask

  task automatic test_basic_negative();
    longint exp_sum;
    prods = '{10, -3, 7, 2};
    gaps  = '{0, 0, 0, 0};
    exp_sum = model_sum(-20);
    run_image(-20, 1'b0, 1'b0);
    if (obs_busy_start !== 1'b1) $display("FAIL neg_busy_start: got %b expected 1", obs_busy_start); else n_pass++;
    n_checks++;
    if (obs_sum_start !== 64'sd0) $display("FAIL neg_clear: got %0d expected 0", obs_sum_start); else n_pass++;
    n_checks++;
    if (obs_done_dly !== 2) $display("FAIL neg_done_delay: got %0d expected 2", obs_done_dly); else n_pass++;
    n_checks++;
    if (obs_done_cnt !== 1) $display("FAIL neg_done_width: got %0d expected 1", obs_done_cnt); else n_pass++;
    n_checks++;
    if (obs_sum !== exp_sum) $display("FAIL neg_sum: got %0d expected %0d", obs_sum, exp_sum); else n_pass++;
    n_checks++;
    if (obs_cat !== 1'b0) $display("FAIL neg_is_cat: got %b expected 0", obs_cat); else n_pass++;
    n_checks++;
    if (obs_hs !== 4) $display("FAIL neg_handshakes: got %0d expected 4", obs_hs); else n_pass++;
    n_checks++;
  endtask

  task automatic test_throttled();
    longint exp_sum;
    prods = '{10, -3, 7, 2};
    gaps  = '{0, 3, 3, 3};
    exp_sum = model_sum(-20);
    run_image(-20, 1'b0, 1'b0);
    if (obs_sum !== exp_sum) $display("FAIL thr_sum: got %0d expected %0d", obs_sum, exp_sum); else n_pass++;
    n_checks++;
    if (obs_hs !== 4) $display("FAIL thr_handshakes: got %0d expected 4", obs_hs); else n_pass++;
    n_checks++;
    if (obs_done_dly !== 2) $display("FAIL thr_done_delay: got %0d expected 2", obs_done_dly); else n_pass++;
    n_checks++;
  endtask

  task automatic test_basic_positive();
    longint exp_sum;
    prods = '{10, -3, 7, 2};
    gaps  = '{0, 0, 0, 0};
    exp_sum = model_sum(-10);
    run_image(-10, 1'b0, 1'b0);
    if (obs_sum !== exp_sum) $display("FAIL pos_sum: got %0d expected %0d", obs_sum, exp_sum); else n_pass++;
    n_checks++;
    if (obs_cat !== 1'b1) $display("FAIL pos_is_cat: got %b expected 1", obs_cat); else n_pass++;
    n_checks++;
    if (obs_sum_end !== exp_sum) $display("FAIL pos_hold_sum: got %0d expected %0d", obs_sum_end, exp_sum); else n_pass++;
    n_checks++;
    if (obs_cat_end !== 1'b1) $display("FAIL pos_hold_cat: got %b expected 1", obs_cat_end); else n_pass++;
    n_checks++;
    if (obs_busy_end !== 1'b0) $display("FAIL pos_idle_busy: got %b expected 0", obs_busy_end); else n_pass++;
    n_checks++;
  endtask

  task automatic test_ignored_controls();
    longint exp_sum;
    bus.prod_valid = 1'b1;
    bus.prod       = ProdWidth'(1000);
    repeat (3) @(negedge clk);
    bus.prod_valid = 1'b0;
    if (sum_now() !== 64'sd6) $display("FAIL idle_valid_sum: got %0d expected 6", sum_now()); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL idle_valid_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++;
    prods = '{10, -3, 7, 2};
    gaps  = '{0, 2, 0, 1};
    exp_sum = model_sum(-20);
    run_image(-20, 1'b1, 1'b1);
    if (obs_sum !== exp_sum) $display("FAIL ign_sum: got %0d expected %0d", obs_sum, exp_sum); else n_pass++;
    n_checks++;
    if (obs_hs !== 4) $display("FAIL ign_handshakes: got %0d expected 4", obs_hs); else n_pass++;
    n_checks++;
    if (obs_busy_end !== 1'b0) $display("FAIL ign_done_start: got busy %b expected 0", obs_busy_end); else n_pass++;
    n_checks++;
    if (obs_sum_end !== exp_sum) $display("FAIL ign_hold_sum: got %0d expected %0d", obs_sum_end, exp_sum); else n_pass++;
    n_checks++;
  endtask

  task automatic test_extremes();
    longint big;
    longint exp_sum;
    big   = -(64'sd1 <<< 32);
    prods = '{big, big, big, big};
    gaps  = '{0, 0, 0, 0};
    exp_sum = -(64'sd1 <<< 34) - 128;
    if (model_sum(-128) !== exp_sum) $display("FAIL ext_model: got %0d expected %0d", model_sum(-128), exp_sum); else n_pass++;
    n_checks++;
    run_image(-128, 1'b0, 1'b0);
    if (obs_sum !== exp_sum) $display("FAIL ext_sum: got %0d expected %0d", obs_sum, exp_sum); else n_pass++;
    n_checks++;
    if (obs_cat !== 1'b0) $display("FAIL ext_is_cat: got %b expected 0", obs_cat); else n_pass++;
    n_checks++;
  endtask

  task automatic test_abort();
    int done_seen = 0;
    longint exp_sum;
    bus.bias  = WeightPrecision'(-5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = ProdWidth'(100);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (bus.busy !== 1'b0) $display("FAIL abort_async_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++;
    if (bus.prod_ready !== 1'b0) $display("FAIL abort_async_ready: got %b expected 0", bus.prod_ready); else n_pass++;
    n_checks++;
    if (sum_now() !== 64'sd0) $display("FAIL abort_async_sum: got %0d expected 0", sum_now()); else n_pass++;
    n_checks++;
    if (bus.is_cat !== 1'b1) $display("FAIL abort_async_cat: got %b expected 1", bus.is_cat); else n_pass++;
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    rst_n          = 1'b1;
    bus.prod_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    if (done_seen !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_seen); else n_pass++;
    n_checks++;
    prods = '{-50, 33, 12, 9};
    gaps  = '{1, 0, 0, 0};
    exp_sum = model_sum(7);
    run_image(7, 1'b0, 1'b0);
    if (obs_sum !== exp_sum) $display("FAIL abort_next_sum: got %0d expected %0d", obs_sum, exp_sum); else n_pass++;
    n_checks++;
  endtask

  task automatic test_random();
    longint exp_sum;
    longint b;
    for (int img = 0; img < 4; img++) begin
      prods.delete();
      gaps.delete();
      for (int k = 0; k < NumPixels; k++) begin
        prods.push_back(longint'($urandom_range(0, 255)) * (longint'($urandom_range(0, 255)) - 128));
        gaps.push_back(int'($urandom_range(0, 2)));
      end
      b = longint'($urandom_range(0, 255)) - 128;
      exp_sum = model_sum(b);
      run_image(b, 1'b0, 1'b0);
      if (obs_sum !== exp_sum) $display("FAIL rnd_sum[%0d]: got %0d expected %0d", img, obs_sum, exp_sum); else n_pass++;
      n_checks++;
      if (obs_cat !== (exp_sum >= 0)) $display("FAIL rnd_is_cat[%0d]: got %b expected %b", img, obs_cat, exp_sum >= 0); else n_pass++;
      n_checks++;
      if (obs_done_dly !== 2) $display("FAIL rnd_done_delay[%0d]: got %0d expected 2", img, obs_done_dly); else n_pass++;
      n_checks++;
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.bias       = '0;
    test_reset();
    test_basic_negative();
    test_throttled();
    test_basic_positive();
    test_ignored_controls();
    test_extremes();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
